// File: rtl/ray_dispatcher_if.sv
// Ray dispatcher bus: frame/ray handshake toward the ray calculator and
// column-buffer write port. The slave modport is the dispatcher itself.
interface ray_dispatcher_if;
  logic        frame_start;
  logic        ray_done;
  logic [11:0] distance_x;
  logic [11:0] distance_y;
  logic        prev_side;
  logic        is_new_ray;
  logic [9:0]  ray_index;
  logic [1:0]  fsm_state;
  logic        col_we;
  logic [9:0]  col_addr;
  logic [8:0]  col_height;
  logic        col_side;
  logic        frame_done;

  modport master (
    output frame_start, ray_done, distance_x, distance_y, prev_side,
    input  is_new_ray, ray_index, fsm_state, col_we, col_addr,
           col_height, col_side, frame_done
  );

  modport slave (
    input  frame_start, ray_done, distance_x, distance_y, prev_side,
    output is_new_ray, ray_index, fsm_state, col_we, col_addr,
           col_height, col_side, frame_done
  );
endinterface

// File: rtl/ray_dispatcher.sv
// Ray dispatcher: walks a frame column by column, issues one ray per column,
// converts the returned perpendicular distance into a wall height with a
// 17-step restoring divider and writes it to the column buffer.
// Optional per-ray watchdog: define RAY_TIMEOUT_EN.
module ray_dispatcher #(
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned SCREEN_H       = 480,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic            clk,
  input logic            reset,
  ray_dispatcher_if.slave bus
);

  localparam int unsigned IDX_W = 10;
  localparam int unsigned HGT_W = 9;
  localparam int unsigned DST_W = 12;
  localparam int unsigned QUO_W = 17;
  localparam int unsigned REM_W = DST_W + 1;
  localparam int unsigned CNT_W = 5;
  localparam logic [QUO_W-1:0] DIVIDEND = QUO_W'(SCREEN_H * 256);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DIV, S_WRITE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ray_index_q, ray_index_d;
  logic [DST_W-1:0]   dist_q, dist_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [QUO_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
  logic [HGT_W-1:0]   col_height_q, col_height_d;
  logic               col_side_q, col_side_d;
  logic               frame_done_q, frame_done_d;
  logic               is_new_ray_q, is_new_ray_d;
  logic               col_we_q, col_we_d;
  logic [1:0]         fsm_state_q, fsm_state_d;

`ifdef RAY_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
`endif

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits
  logic [REM_W-1:0] rem_sh, rem_nx;
  logic             rem_ge;
  logic [QUO_W-1:0] quo_nx;
  logic [HGT_W-1:0] height_sat;

  always_comb begin
    rem_sh     = {rem_q[REM_W-2:0], quo_q[QUO_W-1]};
    rem_ge     = (rem_sh >= {1'b0, dist_q});
    rem_nx     = rem_ge ? (rem_sh - {1'b0, dist_q}) : rem_sh;
    quo_nx     = {quo_q[QUO_W-2:0], rem_ge};
    height_sat = (quo_nx > QUO_W'(SCREEN_H)) ? HGT_W'(SCREEN_H) : HGT_W'(quo_nx);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    ray_index_d  = ray_index_q;
    dist_d       = dist_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    div_cnt_d    = div_cnt_q;
    col_height_d = col_height_q;
    col_side_d   = col_side_q;
    frame_done_d = 1'b0;
`ifdef RAY_TIMEOUT_EN
    wd_cnt_d     = wd_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.frame_start) begin
          ray_index_d = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef RAY_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        // ray_done wins over a coinciding watchdog expiry
        if (bus.ray_done) begin
          dist_d     = bus.prev_side ? bus.distance_y : bus.distance_x;
          col_side_d = bus.prev_side;
          rem_d      = '0;
          quo_d      = DIVIDEND;
          div_cnt_d  = '0;
          state_d    = S_DIV;
        end
`ifdef RAY_TIMEOUT_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          col_height_d = '0;
          col_side_d   = 1'b0;
          state_d      = S_WRITE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
`endif
      end
      S_DIV: begin
        rem_d     = rem_nx;
        quo_d     = quo_nx;
        div_cnt_d = div_cnt_q + CNT_W'(1);
        if (div_cnt_q == CNT_W'(QUO_W - 1)) begin
          col_height_d = height_sat;
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        if (ray_index_q == IDX_W'(SCREEN_W - 1)) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          ray_index_d = ray_index_q + IDX_W'(1);
          state_d     = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    is_new_ray_d = (state_d == S_ISSUE);
    col_we_d     = (state_d == S_WRITE);
    case (state_d)
      S_IDLE:          fsm_state_d = 2'b00;
      S_ISSUE, S_WAIT: fsm_state_d = 2'b01;
      S_DIV:           fsm_state_d = 2'b10;
      S_WRITE:         fsm_state_d = 2'b11;
      default:         fsm_state_d = 2'b00;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ray_index_q  <= '0;
      dist_q       <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      div_cnt_q    <= '0;
      col_height_q <= '0;
      col_side_q   <= 1'b0;
      frame_done_q <= 1'b0;
      is_new_ray_q <= 1'b0;
      col_we_q     <= 1'b0;
      fsm_state_q  <= 2'b00;
`ifdef RAY_TIMEOUT_EN
      wd_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ray_index_q  <= ray_index_d;
      dist_q       <= dist_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      div_cnt_q    <= div_cnt_d;
      col_height_q <= col_height_d;
      col_side_q   <= col_side_d;
      frame_done_q <= frame_done_d;
      is_new_ray_q <= is_new_ray_d;
      col_we_q     <= col_we_d;
      fsm_state_q  <= fsm_state_d;
`ifdef RAY_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
`endif
    end
  end

  assign bus.is_new_ray = is_new_ray_q;
  assign bus.ray_index  = ray_index_q;
  assign bus.fsm_state  = fsm_state_q;
  assign bus.col_we     = col_we_q;
  assign bus.col_addr   = ray_index_q;
  assign bus.col_height = col_height_q;
  assign bus.col_side   = col_side_q;
  assign bus.frame_done = frame_done_q;

endmodule
